// File: rtl/calc_core.sv
// Sequential signed calculator: add/sub/mul in one EXEC cycle, div/mod by restoring division.
// Define CALC_DIVMOD_EN to build the DIV/FIX datapath; otherwise div/mod report err.
module calc_core #(
  parameter int unsigned W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2*W-1:0]   result,
  output logic             neg,
  output logic [2*W-1:0]   mag
);

  typedef enum logic [2:0] {StIdle, StExec, StDiv, StFix, StDone} state_e;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpMul = 3'b010;
`ifdef CALC_DIVMOD_EN
  localparam logic [2:0] OpDiv = 3'b011;
  localparam logic [2:0] OpMod = 3'b100;
  localparam int unsigned CW = $clog2(W) + 1;
`endif

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [2*W-1:0]   result_q, result_d;
  logic [2*W-1:0]   ax, bx;

  assign ax = {{W{a_q[W-1]}}, a_q};
  assign bx = {{W{b_q[W-1]}}, b_q};

`ifdef CALC_DIVMOD_EN
  logic [W-1:0]     rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic [W:0]       sh;
  logic             ge;

  // Partial remainder shifted left with the next dividend bit pulled in from the quotient reg.
  assign sh = {rem_q, quo_q[W-1]};
  assign ge = sh >= {1'b0, dvs_q};
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    err_d    = err_q;
    result_d = result_q;
`ifdef CALC_DIVMOD_EN
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StExec;
          op_d    = op;
          a_d     = a;
          b_d     = b;
          err_d   = 1'b0;
        end
      end
      StExec: begin
        state_d = StDone;
        case (op_q)
          OpAdd: result_d = ax + bx;
          OpSub: result_d = ax - bx;
          OpMul: result_d = ax * bx;
`ifdef CALC_DIVMOD_EN
          OpDiv, OpMod: begin
            if (b_q == '0) begin
              err_d    = 1'b1;
              result_d = '0;
            end else begin
              state_d = StDiv;
              rem_d   = '0;
              quo_d   = a_q[W-1] ? -a_q : a_q;
              dvs_d   = b_q[W-1] ? -b_q : b_q;
              cnt_d   = CW'(W - 1);
              qneg_d  = a_q[W-1] ^ b_q[W-1];
              rneg_d  = a_q[W-1];
            end
          end
`endif
          default: begin
            err_d    = 1'b1;
            result_d = '0;
          end
        endcase
      end
`ifdef CALC_DIVMOD_EN
      StDiv: begin
        rem_d = ge ? W'(sh - {1'b0, dvs_q}) : sh[W-1:0];
        quo_d = {quo_q[W-2:0], ge};
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFix: begin
        state_d = StDone;
        if (op_q == OpDiv) begin
          result_d = qneg_q ? -{{W{1'b0}}, quo_q} : {{W{1'b0}}, quo_q};
        end else begin
          result_d = rneg_q ? -{{W{1'b0}}, rem_q} : {{W{1'b0}}, rem_q};
        end
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
`ifdef CALC_DIVMOD_EN
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
`ifdef CALC_DIVMOD_EN
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;
  assign neg    = result_q[2*W-1];
  assign mag    = neg ? -result_q : result_q;

endmodule

// File: tb/tb_calc_core.sv
// Self-checking bench for calc_core: cycle-level reference model plus directed literal checks.
module tb_calc_core;
  localparam int unsigned W = 8;
`ifdef CALC_DIVMOD_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif
  localparam int DivLat = W + 3;

  logic           clk = 1'b0;
  logic           rst, start;
  logic [2:0]     op;
  logic [W-1:0]   a, b;
  logic           busy, done, err, neg;
  logic [2*W-1:0] result, mag;

  calc_core #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .err(err), .result(result), .neg(neg), .mag(mag)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the operation definitions.
  task automatic model_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int v, output bit e, output int lat);
    int sx, sy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    v = 0;
    e = 1'b0;
    lat = 2;
    case (o)
      3'd0: v = sx + sy;
      3'd1: v = sx - sy;
      3'd2: v = sx * sy;
`ifdef CALC_DIVMOD_EN
      3'd3, 3'd4: begin
        if (sy == 0) e = 1'b1;
        else begin
          v = (o == 3'd3) ? sx / sy : sx % sy;
          lat = DivLat;
        end
      end
`endif
      default: e = 1'b1;
    endcase
  endtask

  bit m_busy = 0, m_done = 0, m_err = 0, p_err;
  int m_val = 0, m_left = 0, p_val, p_lat;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_err = 0; m_val = 0; m_left = 0;
    end else if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_val  = p_val;
        m_err  = p_err;
        m_done = 1;
      end
    end else if (start) begin
      model_op(op, a, b, p_val, p_err, p_lat);
      m_busy = 1;
      m_err  = 0;
      m_left = p_lat - 1;
    end
  end

  int             mv;
  logic [2*W-1:0] er, em;

  always @(negedge clk) begin
    if (chk_en) begin
      er = m_val[2*W-1:0];
      mv = (m_val < 0) ? -m_val : m_val;
      em = mv[2*W-1:0];
      chk("busy",   busy,   m_busy);
      chk("done",   done,   m_done);
      chk("err",    err,    m_err);
      chk("result", result, er);
      chk("neg",    neg,    m_val < 0);
      chk("mag",    mag,    em);
    end
  end

  task automatic run_op(input string name, input logic [2:0] o, input int x, input int y,
                        input int exp_lat, input logic [2*W-1:0] exp_res, input bit exp_err);
    int lat;
    @(negedge clk);
    start = 1'b1; op = o; a = x[W-1:0]; b = y[W-1:0];
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_res"}, result, exp_res);
    chk({name, "_err"}, err, exp_err);
  endtask

  int done_cnt;

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);

    run_op("add", 3'd0, -5, 7, 2, 16'h0002, 1'b0);
    chk("add_neg", neg, 0);
    chk("add_mag", mag, 2);
    run_op("mul", 3'd2, -128, -128, 2, 16'h4000, 1'b0);
    run_op("div0", 3'd3, 9, 0, 2, 16'h0000, 1'b1);
    run_op("add11", 3'd0, 1, 1, 2, 16'h0002, 1'b0);
    run_op("div", 3'd3, -7, 2, DivEn ? DivLat : 2, DivEn ? 16'hFFFD : 16'h0, !DivEn);
    chk("div_neg", neg, DivEn);
    chk("div_mag", mag, DivEn ? 3 : 0);
    run_op("mod", 3'd4, -7, 2, DivEn ? DivLat : 2, DivEn ? 16'hFFFF : 16'h0, !DivEn);
    run_op("mod10", 3'd4, 10, 3, DivEn ? DivLat : 2, DivEn ? 16'h0001 : 16'h0, !DivEn);
    run_op("divmin", 3'd3, -128, -1, DivEn ? DivLat : 2, DivEn ? 16'h0080 : 16'h0, !DivEn);
    run_op("sub", 3'd1, 3, 10, 2, 16'hFFF9, 1'b0);
    chk("sub_mag", mag, 7);
    run_op("submin", 3'd1, -128, 127, 2, 16'hFF01, 1'b0);
    run_op("illegal", 3'd7, 5, 5, 2, 16'h0000, 1'b1);
    run_op("mulpos", 3'd2, 12, -11, 2, 16'hFF7C, 1'b0);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op = 3'd0; a = 8'd3; b = 8'd4;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rststart_busy", busy, 0);
    chk("rststart_res", result, 0);

    // Abort a division mid-flight; a stray start while busy must be ignored.
    run_op("pre", 3'd0, 20, 22, 2, 16'h002A, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 8'd100; b = 8'd3;
    done_cnt = 0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (c == 1) chk("abort_busy1", busy, 1);
      if (c == 7) begin
        chk("abort_busy", busy, 0);
        chk("abort_res", result, 0);
      end
      start = (c == 2);
      if (c == 2) begin
        op = 3'd0; a = 8'd1; b = 8'd1;
      end else begin
        a = W'($urandom); b = W'($urandom);
      end
      rst = (c == 6);
    end
    chk("abort_done_cnt", done_cnt, DivEn ? 0 : 1);

    run_op("post", 3'd0, 1, 1, 2, 16'h0002, 1'b0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
